// File: rtl/mem_access_unit_pkg.sv
// Shared types, opType encodings and small decode helpers for the memory stage.
package mem_access_unit_pkg;

    localparam int cXLEN     = 32;
    localparam int cRegAddrW = 5;

    // Memory part of the execute-stage result.
    typedef struct packed {
        logic             rd;      // load requested
        logic             wr;      // store requested
        logic [2:0]       opType;  // funct3 size/sign encoding
        logic [cXLEN-1:0] addr;    // byte address
        logic [cXLEN-1:0] data;    // store data (low lanes)
    } tMemOp;

    // Register-file writeback bundle.
    typedef struct packed {
        logic                 dv;
        logic [cRegAddrW-1:0] addr;
        logic [cXLEN-1:0]     data;
    } tRegOp;

    // Branch part of the execute-stage result; not used by this stage.
    typedef struct packed {
        logic             taken;
        logic [cXLEN-1:0] target;
    } tBrchOp;

    typedef struct packed {
        tMemOp  memOp;
        tRegOp  regOp;
        tBrchOp brchOp;
    } tAluOut;

    typedef enum logic [1:0] {
        eIdle = 2'b00,
        eReq  = 2'b01,
        eResp = 2'b10
    } tMemState;

    typedef enum logic [1:0] {
        eErrNone     = 2'b00,
        eErrMisalign = 2'b01,
        eErrTimeout  = 2'b10,
        eErrIllegal  = 2'b11
    } tMemErr;

    // funct3 encodings; store codes share the low three load codes.
    localparam logic [2:0] eLb  = 3'b000;
    localparam logic [2:0] eLh  = 3'b001;
    localparam logic [2:0] eLw  = 3'b010;
    localparam logic [2:0] eLbu = 3'b100;
    localparam logic [2:0] eLhu = 3'b101;
    localparam logic [2:0] eSb  = 3'b000;
    localparam logic [2:0] eSh  = 3'b001;
    localparam logic [2:0] eSw  = 3'b010;

    // Unsigned variants exist only for loads.
    function automatic logic op_legal(input logic [2:0] op_type, input logic is_store);
        logic legal;
        case (op_type)
            eLb, eLh, eLw: legal = 1'b1;
            eLbu, eLhu:    legal = !is_store;
            default:       legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Halves need an even address, words a multiple of four.
    function automatic logic misaligned(input logic [2:0] op_type, input logic [1:0] offset);
        logic mis;
        case (op_type[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] op_type, input logic [1:0] offset);
        logic [3:0] be;
        case (op_type[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so the byte enables pick the target lane.
    function automatic logic [cXLEN-1:0] store_lanes(input logic [2:0] op_type,
                                                     input logic [cXLEN-1:0] data);
        logic [cXLEN-1:0] lanes;
        case (op_type[1:0])
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Picks the addressed byte/half lane out of a load word and sign- or zero-extends it.
module load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [cXLEN-1:0] rdata,
    input  logic [1:0]       addr,
    input  logic [2:0]       op_type,
    output logic [cXLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select, then extension according to the load encoding.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        byte_lane = rdata[7:0];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        data      = rdata;
        case (addr)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        case (op_type)
            eLb:     data = {{(cXLEN-8){byte_lane[7]}}, byte_lane};
            eLbu:    data = {{(cXLEN-8){1'b0}}, byte_lane};
            eLh:     data = {{(cXLEN-16){half_lane[15]}}, half_lane};
            eLhu:    data = {{(cXLEN-16){1'b0}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs loads/stores over a req/gnt/rvalid bus, stalls upstream while busy,
// and forwards non-memory results to writeback one cycle later.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int pTimeoutW = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  tAluOut           iAluOut,
    input  logic             iAluDv,
    output logic             oStall,
    output logic             oDmemReq,
    output logic             oDmemWe,
    output logic [cXLEN-1:0] oDmemAddr,
    output logic [cXLEN-1:0] oDmemWdata,
    output logic [3:0]       oDmemBe,
    input  logic             iDmemGnt,
    input  logic             iDmemRvalid,
    input  logic [cXLEN-1:0] iDmemRdata,
    output tRegOp            oRegOp,
    output logic             oMemErr,
    output logic [1:0]       oErrCode
);

    localparam logic [pTimeoutW-1:0] cTimeoutMax = '1;

    tMemState             state, state_nxt;
    logic [pTimeoutW-1:0] tmo_cnt, tmo_cnt_nxt;

    tMemOp                mem_op;
    logic                 accept, is_mem, illegal, misalign, timed_out;
    logic                 start_access, load_done, abort;

    logic                 bus_we;
    logic [cXLEN-1:0]     bus_addr, bus_wdata;
    logic [3:0]           bus_be;
    logic [1:0]           lat_offset;
    logic [2:0]           lat_op;
    logic [cRegAddrW-1:0] lat_rd;
    logic [cXLEN-1:0]     load_data;

    tRegOp                reg_op;
    logic                 mem_err;
    tMemErr               err_code;

    logic                 unused_brch;

    assign unused_brch = ^iAluOut.brchOp;
    assign mem_op      = iAluOut.memOp;

    assign accept    = (state == eIdle) && iAluDv;
    assign is_mem    = mem_op.rd | mem_op.wr;
    assign illegal   = (mem_op.rd & mem_op.wr) | (is_mem & !op_legal(mem_op.opType, mem_op.wr));
    assign misalign  = misaligned(mem_op.opType, mem_op.addr[1:0]);
    assign timed_out = (tmo_cnt == cTimeoutMax);

    // State and timeout counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= eIdle;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    // Next state, counter update and bus handshake; a grant or rvalid wins over a same-cycle timeout.
    always_comb begin
        state_nxt    = state;
        tmo_cnt_nxt  = tmo_cnt;
        start_access = 1'b0;
        load_done    = 1'b0;
        abort        = 1'b0;
        oStall       = (state != eIdle);
        oDmemReq     = (state == eReq);
        case (state)
            eIdle: begin
                if (accept && is_mem && !illegal && !misalign) begin
                    start_access = 1'b1;
                    state_nxt    = eReq;
                    tmo_cnt_nxt  = '0;
                end
            end
            eReq: begin
                if (iDmemGnt) begin
                    if (bus_we) state_nxt = eIdle;
                    else        state_nxt = eResp;
                end else if (timed_out) begin
                    abort     = 1'b1;
                    state_nxt = eIdle;
                end
                if (!timed_out) tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
            eResp: begin
                if (iDmemRvalid) begin
                    load_done = 1'b1;
                    state_nxt = eIdle;
                end else if (timed_out) begin
                    abort     = 1'b1;
                    state_nxt = eIdle;
                end
                if (!timed_out) tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
            default: state_nxt = eIdle;
        endcase
    end

    load_extract u_load_extract (
        .rdata   (iDmemRdata),
        .addr    (lat_offset),
        .op_type (lat_op),
        .data    (load_data)
    );

    // Latched bus request, writeback register and single-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            lat_offset <= '0;
            lat_op     <= '0;
            lat_rd     <= '0;
            reg_op     <= '0;
            mem_err    <= 1'b0;
            err_code   <= eErrNone;
        end else begin
            reg_op.dv <= 1'b0;
            mem_err   <= 1'b0;
            err_code  <= eErrNone;
            if (accept) begin
                if (!is_mem) begin
                    reg_op.dv   <= iAluOut.regOp.dv && (iAluOut.regOp.addr != '0);
                    reg_op.addr <= iAluOut.regOp.addr;
                    reg_op.data <= iAluOut.regOp.data;
                end else if (illegal) begin
                    mem_err  <= 1'b1;
                    err_code <= eErrIllegal;
                end else if (misalign) begin
                    mem_err  <= 1'b1;
                    err_code <= eErrMisalign;
                end else if (start_access) begin
                    bus_we     <= mem_op.wr;
                    bus_addr   <= {mem_op.addr[cXLEN-1:2], 2'b00};
                    bus_wdata  <= store_lanes(mem_op.opType, mem_op.data);
                    bus_be     <= byte_enables(mem_op.opType, mem_op.addr[1:0]);
                    lat_offset <= mem_op.addr[1:0];
                    lat_op     <= mem_op.opType;
                    lat_rd     <= iAluOut.regOp.addr;
                end
            end
            if (load_done) begin
                reg_op.dv   <= (lat_rd != '0);
                reg_op.addr <= lat_rd;
                reg_op.data <= load_data;
            end
            if (abort) begin
                mem_err  <= 1'b1;
                err_code <= eErrTimeout;
            end
        end
    end

    assign oDmemWe    = bus_we;
    assign oDmemAddr  = bus_addr;
    assign oDmemWdata = bus_wdata;
    assign oDmemBe    = bus_be;
    assign oRegOp     = reg_op;
    assign oMemErr    = mem_err;
    assign oErrCode   = err_code;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a writeback/error scoreboard.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic             clk;
    logic             rst;
    tAluOut           alu_in;
    logic             alu_dv;
    logic             stall;
    logic             dmem_req;
    logic             dmem_we;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_wdata;
    logic [3:0]       dmem_be;
    logic             dmem_gnt;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    tRegOp            reg_out;
    logic             mem_err;
    logic [1:0]       err_code;

    int               checks = 0;
    int               errors = 0;
    tRegOp            wb_q[$];
    logic [1:0]       err_q[$];

    mem_access_unit #(.pTimeoutW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .iAluOut     (alu_in),
        .iAluDv      (alu_dv),
        .oStall      (stall),
        .oDmemReq    (dmem_req),
        .oDmemWe     (dmem_we),
        .oDmemAddr   (dmem_addr),
        .oDmemWdata  (dmem_wdata),
        .oDmemBe     (dmem_be),
        .iDmemGnt    (dmem_gnt),
        .iDmemRvalid (dmem_rvalid),
        .iDmemRdata  (dmem_rdata),
        .oRegOp      (reg_out),
        .oMemErr     (mem_err),
        .oErrCode    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any writeback or error pulse seen there.
    task automatic cycle();
        tRegOp      exp_wb;
        logic [1:0] exp_err;
        @(negedge clk);
        if (reg_out.dv) begin
            if (wb_q.size() == 0) check("stray_wb", reg_out.dv, 1'b0);
            else begin
                exp_wb = wb_q.pop_front();
                check("wb", reg_out, exp_wb);
            end
        end
        if (mem_err) begin
            if (err_q.size() == 0) check("stray_err", mem_err, 1'b0);
            else begin
                exp_err = err_q.pop_front();
                check("err_code", err_code, exp_err);
            end
        end
    endtask

    // Present one op for a single cycle; the unit must be idle.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd_addr, input logic rdv);
        alu_in.memOp.rd     = rd;
        alu_in.memOp.wr     = wr;
        alu_in.memOp.opType = op;
        alu_in.memOp.addr   = addr;
        alu_in.memOp.data   = data;
        alu_in.regOp.dv     = rdv;
        alu_in.regOp.addr   = rd_addr;
        alu_in.regOp.data   = data;
        alu_in.brchOp       = {1'b1, 32'hFFFF_0000};
        alu_dv = 1'b1;
        cycle();
        alu_dv = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_req"},   dmem_req, 1'b0);
        check({tag, "_we"},    dmem_we, 1'b0);
        check({tag, "_addr"},  dmem_addr, 32'h0);
        check({tag, "_wdata"}, dmem_wdata, 32'h0);
        check({tag, "_be"},    dmem_be, 4'h0);
        check({tag, "_regop"}, reg_out, '0);
        check({tag, "_err"},   mem_err, 1'b0);
        check({tag, "_code"},  err_code, 2'b00);
    endtask

    // Full load: optional grant delay with ignored rvalids during REQ, then gnt, then rvalid.
    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd_addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic [3:0] exp_be, input int gnt_wait);
        tRegOp exp_wb;
        exp_wb.dv   = 1'b1;
        exp_wb.addr = rd_addr;
        exp_wb.data = exp_data;
        if (rd_addr != 5'd0) wb_q.push_back(exp_wb);
        issue(1'b1, 1'b0, op, addr, 32'h0, rd_addr, 1'b0);
        check("ld_req",  dmem_req, 1'b1);
        check("ld_we",   dmem_we, 1'b0);
        check("ld_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("ld_be",   dmem_be, exp_be);
        for (int i = 0; i < gnt_wait; i++) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'hDEAD_0000;
            cycle();
            check("ld_wait_req", dmem_req, 1'b1);
        end
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b1;
        cycle();
        dmem_gnt    = 1'b0;
        check("ld_resp_stall", stall, 1'b1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        cycle();
        dmem_rvalid = 1'b0;
        check("ld_dv",   reg_out.dv, rd_addr != 5'd0);
        check("ld_idle", stall, 1'b0);
        cycle();
        check("ld_pulse", reg_out.dv, 1'b0);
    endtask

    initial begin
        tRegOp exp_wb;
        int    busy;

        rst         = 1'b1;
        alu_in      = '0;
        alu_dv      = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (2) cycle();
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        // Pass-through, then pass-through to x0.
        exp_wb = '{dv: 1'b1, addr: 5'd5, data: 32'h0000_1234};
        wb_q.push_back(exp_wb);
        issue(1'b0, 1'b0, eLw, 32'h0, 32'h0000_1234, 5'd5, 1'b1);
        check("pt_dv",    reg_out.dv, 1'b1);
        check("pt_stall", stall, 1'b0);
        check("pt_req",   dmem_req, 1'b0);
        cycle();
        check("pt_pulse", reg_out.dv, 1'b0);
        issue(1'b0, 1'b0, eLw, 32'h0, 32'h0000_9999, 5'd0, 1'b1);
        check("pt_r0_dv", reg_out.dv, 1'b0);
        cycle();

        // Loads covering lanes and extension.
        do_load(eLb,  32'h0000_1003, 5'd7,  32'h80FF_0000, 32'hFFFF_FF80, 4'b1000, 0);
        do_load(eLbu, 32'h0000_1003, 5'd8,  32'h80FF_0000, 32'h0000_0080, 4'b1000, 0);
        do_load(eLh,  32'h0000_1002, 5'd9,  32'h80FF_0000, 32'hFFFF_80FF, 4'b1100, 1);
        do_load(eLhu, 32'h0000_1000, 5'd10, 32'h1234_F00D, 32'h0000_F00D, 4'b0011, 0);
        do_load(eLb,  32'h0000_1001, 5'd11, 32'h1234_5678, 32'h0000_0056, 4'b0010, 2);
        do_load(eLw,  32'h0000_1004, 5'd0,  32'hCAFE_BABE, 32'hCAFE_BABE, 4'b1111, 0);

        // Half store with a delayed grant; bus must hold steady.
        issue(1'b0, 1'b1, eSh, 32'h0000_2002, 32'hABCD_1234, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("sh_req",   dmem_req, 1'b1);
            check("sh_we",    dmem_we, 1'b1);
            check("sh_addr",  dmem_addr, 32'h0000_2000);
            check("sh_be",    dmem_be, 4'b1100);
            check("sh_wdata", dmem_wdata, 32'h1234_1234);
            if (i < 2) cycle();
        end
        dmem_gnt = 1'b1;
        cycle();
        dmem_gnt = 1'b0;
        check("sh_done_req",   dmem_req, 1'b0);
        check("sh_done_stall", stall, 1'b0);
        check("sh_no_wb",      reg_out.dv, 1'b0);
        exp_wb = '{dv: 1'b1, addr: 5'd6, data: 32'h0000_0055};
        wb_q.push_back(exp_wb);
        issue(1'b0, 1'b0, eLw, 32'h0, 32'h0000_0055, 5'd6, 1'b1);
        check("after_st_dv", reg_out.dv, 1'b1);

        // Byte store replication.
        issue(1'b0, 1'b1, eSb, 32'h0000_2001, 32'h0000_00A5, 5'd0, 1'b0);
        check("sb_be",    dmem_be, 4'b0010);
        check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        dmem_gnt = 1'b1;
        cycle();
        dmem_gnt = 1'b0;
        check("sb_done_stall", stall, 1'b0);

        // Error paths: misaligned, read+write, illegal encodings.
        err_q.push_back(2'b01);
        issue(1'b1, 1'b0, eLw, 32'h0000_3001, 32'h0, 5'd4, 1'b0);
        check("mis_err",   mem_err, 1'b1);
        check("mis_req",   dmem_req, 1'b0);
        check("mis_stall", stall, 1'b0);
        cycle();
        check("mis_pulse", mem_err, 1'b0);
        err_q.push_back(2'b01);
        issue(1'b0, 1'b1, eSh, 32'h0000_3001, 32'h0, 5'd0, 1'b0);
        check("mis_sh_err", mem_err, 1'b1);
        err_q.push_back(2'b11);
        issue(1'b1, 1'b1, eLw, 32'h0000_3000, 32'h0, 5'd4, 1'b0);
        check("rw_err", mem_err, 1'b1);
        check("rw_dv",  reg_out.dv, 1'b0);
        check("rw_req", dmem_req, 1'b0);
        err_q.push_back(2'b11);
        issue(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd4, 1'b0);
        check("ill_ld_err", mem_err, 1'b1);
        err_q.push_back(2'b11);
        issue(1'b0, 1'b1, eLbu, 32'h0000_3000, 32'h0, 5'd0, 1'b0);
        check("ill_st_err", mem_err, 1'b1);
        cycle();

        // Timeout after grant with no rvalid; later stray rvalid ignored.
        err_q.push_back(2'b10);
        issue(1'b1, 1'b0, eLw, 32'h0000_4000, 32'h0, 5'd9, 1'b0);
        check("to_stall", stall, 1'b1);
        busy = 1;
        dmem_gnt = 1'b1;
        cycle();
        dmem_gnt = 1'b0;
        while (stall && busy < 40) begin
            busy++;
            cycle();
        end
        check("to_stall_drop", stall, 1'b0);
        check("to_len",  64'(busy >= 15 && busy <= 16), 64'd1);
        check("to_err",  mem_err, 1'b1);
        check("to_code", err_code, 2'b10);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        cycle();
        cycle();
        dmem_rvalid = 1'b0;
        check("to_stray_rv", reg_out.dv, 1'b0);

        // Reset while waiting for rvalid, then a clean load.
        issue(1'b1, 1'b0, eLw, 32'h0000_5000, 32'h0, 5'd3, 1'b0);
        dmem_gnt = 1'b1;
        cycle();
        dmem_gnt = 1'b0;
        check("rst_resp_stall", stall, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all_zero("mid_rst");
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        cycle();
        dmem_rvalid = 1'b0;
        check("late_rv_dv",    reg_out.dv, 1'b0);
        check("late_rv_stall", stall, 1'b0);
        do_load(eLw, 32'h0000_5004, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 0);

        cycle();
        check("wb_q_empty",  wb_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
